// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared types and constants for the toggle-handshake clock-domain crossing.
//   cdc_sender_state_t  : sender FSM state encoding (IDLE / WAIT_ACK)
//   CDC_MIN_SYNC_STAGES : smallest synchronizer depth the sender accepts
// -----------------------------------------------------------------------------
package cdc_pkg;

  localparam int CDC_MIN_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_sender_state_t;

endpackage : cdc_pkg

// File: rtl/cdc_sync_chain.sv
// -----------------------------------------------------------------------------
// cdc_sync_chain
// Multi-flop single-bit synchronizer for a level or toggle signal arriving
// asynchronously to clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; every stage loads RESET_VAL
//   d     : asynchronous input bit
//   q     : d delayed through STAGES flops, safe to use in the clk domain
// -----------------------------------------------------------------------------
module cdc_sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbour, giving a true
  // shift chain rather than a single collapsed flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : cdc_sync_chain

// File: rtl/cdc_handshake_sender.sv
// -----------------------------------------------------------------------------
// cdc_handshake_sender
// Source-domain end of a two-phase (toggle) request/acknowledge crossing.
// A word accepted on the valid/ready interface is held on data_out, req_out
// toggles, and the block waits until the synchronized ack toggle matches
// req_out before accepting the next word.
//   clk, rst_n     : source clock, asynchronous active-low reset
//   in_valid       : source offers a word
//   in_data        : offered word, captured only on accept
//   in_ready       : registered; block can accept this cycle
//   req_out        : registered toggle request to the destination domain
//   data_out       : registered word, stable while a transfer is outstanding
//   ack_in         : toggle acknowledge, asynchronous to clk
//   busy           : registered; transfer outstanding
//   protocol_error : sticky; ack toggled while no request was outstanding
// -----------------------------------------------------------------------------
module cdc_handshake_sender
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic                  protocol_error
);

  // A single flop gives no metastability margin on ack_in; refuse to build.
  if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("cdc_handshake_sender: SYNC_STAGES must be at least %0d",
           CDC_MIN_SYNC_STAGES);
  end

  cdc_sender_state_t     state, state_next;
  logic                  ack_sync;
  logic                  req_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  ready_next;
  logic                  busy_next;
  logic                  error_next;

  // The only consumer of ack_in; everything else sees ack_sync.
  cdc_sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (ack_sync)
  );

  // NOTE: every register, including the data word, is reset; the destination
  // side is reset together with this block, so both start with req == ack == 0
  // and a defined data bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_out        <= 1'b0;
      data_out       <= '0;
      in_ready       <= 1'b0;
      busy           <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state          <= state_next;
      req_out        <= req_next;
      data_out       <= data_next;
      in_ready       <= ready_next;
      busy           <= busy_next;
      protocol_error <= error_next;
    end
  end

  // NOTE: each output of this block is given a hold-value default before the
  // case statement, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    state_next = state;
    req_next   = req_out;
    data_next  = data_out;
    ready_next = in_ready;
    busy_next  = busy;
    error_next = protocol_error;

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_next  = in_data;
          req_next   = ~req_out;
          ready_next = 1'b0;
          busy_next  = 1'b1;
          state_next = WAIT_ACK;
        end else begin
          // Also raises in_ready on the first edge after reset release.
          ready_next = 1'b1;
        end
        // In IDLE the ack must already match the last request; any
        // difference is an ack toggle nobody asked for.
        if (ack_sync != req_out) begin
          error_next = 1'b1;
        end
      end

      WAIT_ACK: begin
        // Completion does not accept in the same cycle: in_ready was low
        // here, so the earliest next accept is one edge later.
        if (ack_sync == req_out) begin
          ready_next = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule : cdc_handshake_sender

// File: tb/tb_cdc_handshake_sender.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_sender
// Directed bench for cdc_handshake_sender (DATA_WIDTH=8, SYNC_STAGES=2).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. after the edge under test has settled.
// An ack_in changed between edges E and E+1 is captured at E+1, reaches
// ack_sync at E+2 and is acted on at E+3.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_sender;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          ack_in;
  logic          busy;
  logic          protocol_error;

  logic          ack_drv;
  logic          echo;

  int checks = 0;
  int errors = 0;

  // Destination model: either a directly driven ack or an instant echo of req.
  assign ack_in = echo ? req_out : ack_drv;

  cdc_handshake_sender #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .req_out        (req_out),
    .data_out       (data_out),
    .ack_in         (ack_in),
    .busy           (busy),
    .protocol_error (protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with ack low, release between edges, then one edge to raise in_ready.
  task automatic do_reset(input logic echo_mode);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    echo     = 1'b0;
    ack_drv  = 1'b0;
    step();
    step();
    echo  = echo_mode;
    rst_n = 1'b1;
    step();
  endtask

  logic [DW-1:0] words [3];
  logic          reqs  [3];
  int            n;

  initial begin
    words = '{8'h01, 8'h02, 8'h03};
    reqs  = '{1'b1, 1'b0, 1'b1};

    // ---------------- reset ----------------
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    echo     = 1'b0;
    ack_drv  = 1'b0;
    step();
    check("rst_in_ready_held", in_ready, 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_req", req_out, 0);
    check("rst_data", data_out, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_perr", protocol_error, 0);

    // ---------------- single transfer + backpressure ----------------
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();                                   // edge N: accept
    check("st_req", req_out, 1);
    check("st_data", data_out, 8'hA5);
    check("st_busy", busy, 1);
    check("st_ready", in_ready, 0);
    in_data = 8'h5A;                          // new word offered while not ready
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_data", data_out, 8'hA5);
      check("bp_req", req_out, 1);
      check("bp_ready", in_ready, 0);
    end
    ack_drv  = 1'b1;                          // destination acknowledges
    in_valid = 1'b0;
    step();
    check("st_wait1_ready", in_ready, 0);
    step();
    check("st_wait2_ready", in_ready, 0);
    check("st_wait2_busy", busy, 1);
    step();
    check("st_done_ready", in_ready, 1);
    check("st_done_busy", busy, 0);
    check("st_done_data", data_out, 8'hA5);
    step();
    check("st_no_perr", protocol_error, 0);
    check("st_no_extra_req", req_out, 1);

    // ---------------- spurious ack ----------------
    ack_drv = 1'b0;                           // toggle with nothing outstanding
    step();
    check("sp_perr_early", protocol_error, 0);
    step();
    step();
    check("sp_perr_set", protocol_error, 1);
    step();
    step();
    check("sp_perr_sticky", protocol_error, 1);
    check("sp_still_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();                                   // req goes 1->0, already equals ack
    in_valid = 1'b0;
    check("sp_req", req_out, 0);
    check("sp_data", data_out, 8'h3C);
    check("sp_busy", busy, 1);
    step();
    check("sp_done_ready", in_ready, 1);
    check("sp_done_busy", busy, 0);
    check("sp_perr_kept", protocol_error, 1);

    // ---------------- back-to-back with instant ack ----------------
    do_reset(1'b1);
    check("b2b_perr_cleared", protocol_error, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = words[k];
      check("b2b_ready", in_ready, 1);
      step();                                 // accept
      check("b2b_data", data_out, words[k]);
      check("b2b_req", req_out, reqs[k]);
      check("b2b_busy", busy, 1);
      n = 0;
      while (!in_ready && n < 10) begin
        step();
        n++;
      end
      // 3 edges to completion + 1 accept edge = period of 4.
      check("b2b_spacing", n, 3);
      check("b2b_data_held", data_out, words[k]);
    end
    in_valid = 1'b0;
    step();
    check("b2b_final_req", req_out, 1);
    check("b2b_final_data", data_out, 8'h03);
    check("b2b_perr", protocol_error, 0);

    // ---------------- reset mid-transfer ----------------
    do_reset(1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_valid = 1'b0;
    check("mr_req_set", req_out, 1);
    check("mr_data_set", data_out, 8'hFF);
    #2;
    rst_n = 1'b0;                             // between edges
    #1;
    check("mr_req_clr", req_out, 0);
    check("mr_data_clr", data_out, 8'h00);
    check("mr_busy_clr", busy, 0);
    check("mr_ready_clr", in_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_ready_back", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    in_valid = 1'b0;
    check("mr_req2", req_out, 1);
    check("mr_data2", data_out, 8'h77);
    ack_drv = 1'b1;
    step();
    step();
    step();
    check("mr_done_ready", in_ready, 1);
    check("mr_done_busy", busy, 0);
    check("mr_perr", protocol_error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cdc_handshake_sender
